// File: rtl/nco_phase_acc.sv
// Numerically controlled oscillator for a Costas loop: PI loop filter on the
// phase-error feedback, clamped frequency word, phase accumulator and lock detector.
module nco_phase_acc #(
  parameter int                      WIDTH       = 16,
  parameter logic signed [WIDTH-1:0] FREE_FREQ   = 16'h4000,
  parameter logic signed [WIDTH-1:0] FREQ_LIMIT  = 16'h1000,
  parameter logic signed [WIDTH-1:0] LOCK_THRESH = 16'h0040,
  parameter int                      LOCK_COUNT  = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [3:0]              KP_SHIFT,
  input  logic [3:0]              KI_SHIFT,
  input  logic [1:0]              mode,
  input  logic signed [WIDTH-1:0] feedback_tdata,
  input  logic                    feedback_tvalid,
  output logic [WIDTH-1:0]        freq_tdata,
  output logic [WIDTH-1:0]        phase_tdata,
  output logic                    phase_tvalid,
  output logic                    locked
);

  localparam int XW = WIDTH + 2;
  localparam int CW = $clog2(LOCK_COUNT + 1);

  localparam logic [1:0] MODE_CLOSED = 2'd0;
  localparam logic [1:0] MODE_HOLD   = 2'd2;

  localparam logic signed [XW-1:0] LIM_P     = XW'(FREQ_LIMIT);
  localparam logic signed [XW-1:0] LIM_N     = -LIM_P;
  localparam logic [CW-1:0]        LOCK_MAX  = CW'(LOCK_COUNT);
  localparam logic [WIDTH-1:0]     MOST_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

  function automatic logic signed [XW-1:0] clamp(input logic signed [XW-1:0] x);
    if (x > LIM_P)      return LIM_P;
    else if (x < LIM_N) return LIM_N;
    else                return x;
  endfunction

  logic signed [XW-1:0] integ_q, integ_d;
  logic [WIDTH-1:0]     freq_q, freq_d;
  logic [WIDTH-1:0]     phase_q;
  logic                 s1_valid_q;
  logic                 phase_valid_q;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 locked_q, locked_d;

  logic signed [XW-1:0] fb_x;
  logic signed [XW-1:0] prop;
  logic signed [XW-1:0] inc;
  logic signed [XW-1:0] integ_next;
  logic signed [WIDTH-1:0] dev;
  logic [WIDTH-1:0]     fb_abs;
  logic                 in_lock;

  // Loop filter: both branches are evaluated in WIDTH+2 bits so sums never wrap
  always_comb begin
    fb_x       = XW'(feedback_tdata);
    prop       = fb_x >>> KP_SHIFT;
    inc        = fb_x >>> KI_SHIFT;
    integ_next = clamp(integ_q + inc);
    integ_d    = integ_q;
    dev        = '0;
    case (mode)
      MODE_CLOSED: begin
        integ_d = integ_next;
        dev     = WIDTH'(clamp(integ_next + prop));
      end
      MODE_HOLD: begin
        dev     = WIDTH'(integ_q);
      end
      default: begin
        integ_d = '0;
        dev     = '0;
      end
    endcase
    freq_d = $unsigned(FREE_FREQ) + $unsigned(dev);
  end

  // Most-negative input negates to itself, so it is excluded explicitly
  always_comb begin
    fb_abs  = feedback_tdata[WIDTH-1] ? $unsigned(-feedback_tdata) : $unsigned(feedback_tdata);
    in_lock = ($unsigned(feedback_tdata) != MOST_NEG) && (fb_abs < $unsigned(LOCK_THRESH));
    cnt_d    = cnt_q;
    locked_d = locked_q;
    if (mode != MODE_CLOSED) begin
      cnt_d    = '0;
      locked_d = 1'b0;
    end else if (feedback_tvalid) begin
      if (in_lock) cnt_d = (cnt_q == LOCK_MAX) ? cnt_q : cnt_q + 1'b1;
      else         cnt_d = '0;
      locked_d = (cnt_d == LOCK_MAX);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      integ_q       <= '0;
      freq_q        <= $unsigned(FREE_FREQ);
      s1_valid_q    <= 1'b0;
      phase_q       <= '0;
      phase_valid_q <= 1'b0;
      cnt_q         <= '0;
      locked_q      <= 1'b0;
    end else begin
      if (feedback_tvalid) begin
        integ_q <= integ_d;
        freq_q  <= freq_d;
      end
      s1_valid_q    <= feedback_tvalid;
      // Stage 2 consumes the frequency word registered by stage 1 one cycle earlier
      if (s1_valid_q) phase_q <= phase_q + freq_q;
      phase_valid_q <= s1_valid_q;
      cnt_q         <= cnt_d;
      locked_q      <= locked_d;
    end
  end

  assign freq_tdata   = freq_q;
  assign phase_tdata  = phase_q;
  assign phase_tvalid = phase_valid_q;
  assign locked       = locked_q;

endmodule

// File: tb/tb_nco_phase_acc.sv
// Self-checking bench for nco_phase_acc: directed vector table, hand-written
// lock/reset sequences, then randomized traffic against an arithmetic reference model.
module tb_nco_phase_acc;

  localparam int LC = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  KP_SHIFT, KI_SHIFT;
  logic [1:0]  mode;
  logic signed [15:0] feedback_tdata;
  logic        feedback_tvalid;
  logic [15:0] freq_tdata, phase_tdata;
  logic        phase_tvalid, locked;

  int n_checks = 0;
  int n_fail   = 0;

  nco_phase_acc #(
    .WIDTH(16), .FREE_FREQ(16'h4000), .FREQ_LIMIT(16'h1000),
    .LOCK_THRESH(16'h0040), .LOCK_COUNT(LC)
  ) dut (
    .clk(clk), .rst(rst), .KP_SHIFT(KP_SHIFT), .KI_SHIFT(KI_SHIFT), .mode(mode),
    .feedback_tdata(feedback_tdata), .feedback_tvalid(feedback_tvalid),
    .freq_tdata(freq_tdata), .phase_tdata(phase_tdata),
    .phase_tvalid(phase_tvalid), .locked(locked)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rst;
    bit [1:0]    mode;
    bit          vld;
    logic [15:0] fb;
    bit [3:0]    kp;
    bit [3:0]    ki;
    logic [15:0] efreq;
    logic [15:0] ephase;
    bit          epv;
    bit          elock;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(bit r, bit [1:0] m, bit v, logic [15:0] fb, bit [3:0] kp,
                              bit [3:0] ki, logic [15:0] ef, logic [15:0] ep, bit epv, bit el);
    vec_t t;
    t.rst = r; t.mode = m; t.vld = v; t.fb = fb; t.kp = kp; t.ki = ki;
    t.efreq = ef; t.ephase = ep; t.epv = epv; t.elock = el;
    tbl.push_back(t);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input bit r, input bit [1:0] m, input bit v, input logic [15:0] fb,
                       input bit [3:0] kp, input bit [3:0] ki);
    rst = r; mode = m; feedback_tvalid = v; feedback_tdata = fb; KP_SHIFT = kp; KI_SHIFT = ki;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model state: loop integrator as a plain integer, lock run length, outputs
  int          m_integ, m_cnt;
  bit          m_locked, m_pv, m_pend;
  logic [15:0] m_freq, m_phase;

  function automatic int clampi(input int x);
    if (x > 32'sh1000)  return 32'sh1000;
    if (x < -32'sh1000) return -32'sh1000;
    return x;
  endfunction

  function automatic void model_step(input bit r, input bit [1:0] m, input bit v,
                                     input logic [15:0] fb, input bit [3:0] kp, input bit [3:0] ki);
    int f, prop, inc, ni, dev;
    if (r) begin
      m_integ = 0; m_cnt = 0; m_locked = 0; m_freq = 16'h4000;
      m_phase = 0; m_pv = 0; m_pend = 0;
      return;
    end
    // A sample accepted last cycle advances the phase by its own frequency word now
    m_pv = m_pend;
    if (m_pend) m_phase = m_phase + m_freq;
    m_pend = v;
    f = int'($signed(fb));
    if (v) begin
      prop = f >>> kp;
      inc  = f >>> ki;
      dev  = 0;
      case (m)
        2'd0: begin ni = clampi(m_integ + inc); dev = clampi(ni + prop); m_integ = ni; end
        2'd2: dev = m_integ;
        default: begin m_integ = 0; dev = 0; end
      endcase
      m_freq = 16'(32'h4000 + dev);
    end
    if (m != 2'd0) begin
      m_cnt = 0; m_locked = 0;
    end else if (v) begin
      if (f > -64 && f < 64) m_cnt = (m_cnt + 1 > LC) ? LC : m_cnt + 1;
      else                   m_cnt = 0;
      m_locked = (m_cnt >= LC);
    end
  endfunction

  initial begin
    bit small_seg;
    bit          r, v;
    bit [1:0]    m;
    logic [15:0] fb;
    bit [3:0]    kp, ki;

    drive(1, 1, 0, 0, 0, 0);

    //   rst mode vld fb      kp ki  freq     phase    pv lock
    add(1, 1, 0, 16'h0000, 0, 0, 16'h4000, 16'h0000, 0, 0);
    add(0, 1, 1, 16'h1234, 0, 0, 16'h4000, 16'h0000, 0, 0);
    add(0, 1, 1, 16'h1234, 0, 0, 16'h4000, 16'h4000, 1, 0);
    add(0, 3, 1, 16'hABCD, 0, 0, 16'h4000, 16'h8000, 1, 0);
    add(0, 1, 1, 16'h0000, 0, 0, 16'h4000, 16'hC000, 1, 0);
    add(0, 1, 1, 16'h0000, 0, 0, 16'h4000, 16'h0000, 1, 0);
    add(0, 1, 0, 16'h0000, 0, 0, 16'h4000, 16'h4000, 1, 0);
    add(0, 1, 0, 16'h0000, 0, 0, 16'h4000, 16'h4000, 0, 0);
    add(1, 0, 0, 16'h0000, 0, 4, 16'h4000, 16'h0000, 0, 0);
    add(0, 0, 1, 16'h0100, 0, 4, 16'h4110, 16'h0000, 0, 0);
    add(0, 0, 0, 16'h0000, 0, 4, 16'h4110, 16'h4110, 1, 0);
    add(0, 0, 0, 16'h0000, 0, 4, 16'h4110, 16'h4110, 0, 0);
    add(0, 2, 1, 16'h7FFF, 0, 4, 16'h4010, 16'h4110, 0, 0);
    add(0, 2, 0, 16'h0000, 0, 4, 16'h4010, 16'h8120, 1, 0);
    add(0, 2, 1, 16'h8000, 0, 4, 16'h4010, 16'h8120, 0, 0);
    add(0, 0, 1, 16'h0000, 0, 4, 16'h4010, 16'hC130, 1, 0);
    add(0, 0, 0, 16'h0000, 0, 4, 16'h4010, 16'h0140, 1, 0);
    add(1, 0, 0, 16'h0000, 0, 4, 16'h4000, 16'h0000, 0, 0);
    add(0, 0, 1, 16'h7FFF, 0, 4, 16'h5000, 16'h0000, 0, 0);
    add(0, 0, 1, 16'h8000, 0, 4, 16'h3000, 16'h5000, 1, 0);
    add(0, 0, 0, 16'h0000, 0, 4, 16'h3000, 16'h8000, 1, 0);
    add(0, 0, 0, 16'h0000, 0, 4, 16'h3000, 16'h8000, 0, 0);
    add(0, 0, 1, 16'h1001, 0, 15, 16'h5000, 16'h8000, 0, 0);
    add(0, 0, 1, 16'h1002, 0, 15, 16'h5000, 16'hD000, 1, 0);
    add(0, 0, 1, 16'hEFFF, 0, 15, 16'h3000, 16'h2000, 1, 0);
    add(0, 0, 0, 16'h0000, 0, 15, 16'h3000, 16'h5000, 1, 0);

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].mode, tbl[i].vld, tbl[i].fb, tbl[i].kp, tbl[i].ki);
      tick();
      chk($sformatf("vec%0d freq", i),   freq_tdata,   tbl[i].efreq);
      chk($sformatf("vec%0d phase", i),  phase_tdata,  tbl[i].ephase);
      chk($sformatf("vec%0d pvalid", i), phase_tvalid, tbl[i].epv);
      chk($sformatf("vec%0d locked", i), locked,       tbl[i].elock);
      $display("vec %0d: freq=%h phase=%h pv=%0b locked=%0b", i, freq_tdata, phase_tdata,
               phase_tvalid, locked);
    end

    // Lock acquisition and each way of losing it
    drive(1, 0, 0, 0, 4, 8); tick();
    for (int k = 0; k < LC; k++) begin
      drive(0, 0, 1, 16'h0010, 4, 8); tick();
      chk($sformatf("lock_acq%0d", k), locked, (k == LC - 1));
    end
    drive(0, 0, 0, 16'h0100, 4, 8); tick();
    chk("lock_idle_hold", locked, 1);
    drive(0, 0, 1, 16'h0100, 4, 8); tick();
    chk("lock_lost_large", locked, 0);
    $display("lock seq: large feedback drops lock, locked=%0b", locked);

    for (int k = 0; k < LC; k++) begin drive(0, 0, 1, 16'hFFC1, 4, 8); tick(); end
    chk("lock_neg_edge", locked, 1);
    drive(0, 0, 1, 16'h8000, 4, 8); tick();
    chk("lock_lost_mostneg", locked, 0);
    $display("lock seq: most-negative feedback drops lock, locked=%0b", locked);

    for (int k = 0; k < LC; k++) begin drive(0, 0, 1, 16'h003F, 4, 8); tick(); end
    chk("lock_thresh_in", locked, 1);
    drive(0, 0, 1, 16'h0040, 4, 8); tick();
    chk("lock_thresh_out", locked, 0);
    $display("lock seq: feedback at threshold drops lock, locked=%0b", locked);

    for (int k = 0; k < LC; k++) begin drive(0, 0, 1, 16'h0010, 4, 8); tick(); end
    chk("lock_relock", locked, 1);
    drive(0, 1, 1, 16'h0010, 4, 8); tick();
    chk("lock_open_clear", locked, 0);
    drive(0, 0, 1, 16'h0010, 4, 8); tick();
    chk("lock_restart_cnt", locked, 0);
    $display("lock seq: OPEN clears lock, locked=%0b", locked);

    // Reset one cycle after a sample drops it from the pipeline
    drive(1, 0, 0, 0, 0, 4); tick();
    drive(0, 0, 1, 16'h0100, 0, 4); tick();
    chk("rst_pre_freq", freq_tdata, 16'h4110);
    drive(1, 0, 0, 0, 0, 4); tick();
    chk("rst_freq", freq_tdata, 16'h4000);
    chk("rst_phase", phase_tdata, 16'h0000);
    chk("rst_pvalid", phase_tvalid, 0);
    for (int k = 0; k < 2; k++) begin
      drive(0, 0, 0, 0, 0, 4); tick();
      chk($sformatf("rst_after%0d_pvalid", k), phase_tvalid, 0);
      chk($sformatf("rst_after%0d_phase", k),  phase_tdata,  16'h0000);
    end
    $display("reset seq: pv=%0b phase=%h freq=%h", phase_tvalid, phase_tdata, freq_tdata);

    // Randomized traffic against the reference model
    drive(1, 0, 0, 0, 0, 0); tick();
    model_step(1, 0, 0, 0, 0, 0);
    small_seg = 1;
    m = 0;
    for (int c = 0; c < 600; c++) begin
      if (c % 40 == 0) begin
        small_seg = ($urandom_range(0, 3) != 0);
        m = ($urandom_range(0, 9) < 7) ? 2'd0 : 2'($urandom_range(1, 3));
      end
      if ($urandom_range(0, 15) == 0) m = 2'($urandom_range(0, 3));
      r  = ($urandom_range(0, 99) == 0);
      v  = ($urandom_range(0, 3) != 0);
      fb = small_seg ? 16'(int'($urandom_range(0, 140)) - 70) : 16'($urandom);
      kp = 4'($urandom_range(0, 15));
      ki = 4'($urandom_range(0, 15));
      drive(r, m, v, fb, kp, ki);
      tick();
      model_step(r, m, v, fb, kp, ki);
      chk($sformatf("rnd%0d freq", c),   freq_tdata,   m_freq);
      chk($sformatf("rnd%0d phase", c),  phase_tdata,  m_phase);
      chk($sformatf("rnd%0d pvalid", c), phase_tvalid, m_pv);
      chk($sformatf("rnd%0d locked", c), locked,       m_locked);
      $display("rnd %0d: rst=%0b mode=%0d v=%0b fb=%h -> freq=%h phase=%h pv=%0b locked=%0b",
               c, r, m, v, fb, freq_tdata, phase_tdata, phase_tvalid, locked);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/nco_phase_acc.md
NCO_PHASE_ACC -- requirements
Module: nco_phase_acc

Interface
REQ-001 SHALL have parameter WIDTH, default 16, phase/frequency/feedback word width.
REQ-002 SHALL have parameter FREE_FREQ, default 16'h4000, signed free-running frequency word (1/4 of 2^WIDTH).
REQ-003 SHALL have parameter FREQ_LIMIT, default 16'h1000, max |frequency deviation| from FREE_FREQ (positive).
REQ-004 SHALL have parameter LOCK_THRESH, default 16'h0040, |feedback| below which a sample counts as "in lock".
REQ-005 SHALL have parameter LOCK_COUNT, default 64, consecutive in-lock samples required to assert locked.
REQ-006 SHALL have ports: clk in 1 clock; rst in 1 reset (synchronous, active-high); reset rst and clock clk exactly as stated.
REQ-007 SHALL have ports: KP_SHIFT in 4 proportional right shift; KI_SHIFT in 4 integral right shift; mode in 2 (0 CLOSED, 1 OPEN, 2 HOLD, 3 treated as OPEN).
REQ-008 SHALL have ports: feedback_tdata in WIDTH signed Costas error; feedback_tvalid in 1 sample strobe.
REQ-009 SHALL have ports: freq_tdata out WIDTH signed frequency word; phase_tdata out WIDTH phase accumulator; phase_tvalid out 1; locked out 1.

Function
REQ-010 SHALL accept a sample on every clk where feedback_tvalid=1; no backpressure; idle cycles hold all state.
REQ-011 Stage 1 (per accepted sample) SHALL compute prop = feedback_tdata >>> KP_SHIFT and inc = feedback_tdata >>> KI_SHIFT, arithmetic shifts, sign-extended to WIDTH+2.
REQ-012 CLOSED: integ_next = clamp(integ + inc, -FREQ_LIMIT, +FREQ_LIMIT); dev = clamp(integ_next + prop, ±FREQ_LIMIT); integ <= integ_next.
REQ-013 OPEN (mode 1 or 3): integ <= 0, dev = 0; feedback_tdata ignored.
REQ-014 HOLD: integ unchanged, dev = integ; feedback_tdata ignored.
REQ-015 freq_tdata SHALL register FREE_FREQ + dev, truncated modulo 2^WIDTH, one cycle after the accepted sample.
REQ-016 Stage 2 SHALL update phase_tdata <= phase_tdata + freq_tdata (wrap modulo 2^WIDTH) one cycle after stage 1; phase_tvalid high exactly that cycle.
REQ-017 Total latency feedback_tvalid -> phase_tvalid SHALL be 2 cycles; back-to-back samples produce back-to-back phase_tvalid.
REQ-018 mode SHALL be sampled in the same cycle as the accepted sample; a change applies to the next accepted sample, samples already in stage 2 are unaffected.
REQ-019 Lock detector (CLOSED only) SHALL keep a saturating counter: accepted sample with |feedback_tdata| < LOCK_THRESH increments; otherwise clears; most-negative value counts as out-of-lock.
REQ-020 locked SHALL be registered high once counter reaches LOCK_COUNT, and go low the cycle after an out-of-lock sample is accepted.
REQ-021 In OPEN or HOLD, counter and locked SHALL be forced to 0 on the next clock.
REQ-022 Clamp boundaries SHALL be inclusive: dev = +FREQ_LIMIT and -FREQ_LIMIT are legal, never exceeded.

Reset
REQ-023 On rst: phase_tdata=0, phase_tvalid=0, freq_tdata=FREE_FREQ, integ=0, lock counter=0, locked=0, pipeline valids=0.
REQ-024 rst mid-operation SHALL drop in-flight samples; no phase_tvalid in the two cycles after rst deasserts unless new samples arrive.

Verification
REQ-025 OPEN, tvalid high 5 cycles -> freq 0x4000; phase 0x4000,0x8000,0xC000,0x0000,0x4000 with phase_tvalid high cycles 2..6.
REQ-026 CLOSED, KP=0, KI=4, one sample fb=0x0100 -> integ 0x0010, freq_tdata 0x4110 at +1, phase_tdata 0x4110 with phase_tvalid at +2.
REQ-027 CLOSED, KP=0, fb=0x7FFF -> dev clamped, freq_tdata 0x5000; fb=0x8000 -> freq_tdata 0x3000.
REQ-028 After REQ-026 state, mode=HOLD, fb=0x7FFF -> freq_tdata 0x4010, integ stays 0x0010, locked=0.
REQ-029 CLOSED, LOCK_COUNT=8, 8 samples fb=0x0010 -> locked=1 after 8th; then fb=0x0100 -> locked=0 next cycle.
REQ-030 rst asserted one cycle after a sample -> phase_tvalid stays 0, phase_tdata=0, freq_tdata=0x4000.
